// File: rtl/control_sequencer.sv
// Multi-cycle IF/EX control sequencer: instruction register, class decode, immediate generation, control word.
// Optional retired-instruction counter enabled by defining CTRL_SEQ_PERF_EN.
module control_sequencer #(
  parameter int DATA_W = 64,
  parameter int CW_W   = 34
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic [4:0]        status,
  input  logic              mem_ready,
  output logic              instr_req,
  output logic [CW_W-1:0]   control_word,
  output logic [DATA_W-1:0] constant,
  output logic [2:0]        state,
  output logic              illegal
`ifdef CTRL_SEQ_PERF_EN
  ,
  output logic [31:0]       retired
`endif
);

  typedef enum logic [2:0] {S_IF = 3'd0, S_EX0 = 3'd1, S_EX1 = 3'd2, S_EX2 = 3'd3} state_t;
  typedef enum logic [2:0] {C_ILL, C_ADD, C_MOVZ, C_B, C_CB, C_BC, C_LDST} cls_t;

  state_t      state_q, state_d;
  logic [31:0] ir;
  logic [7:0]  cw;
  cls_t        cls;

  function automatic cls_t decode(input logic [31:0] i);
    if (i[28:24] == 5'b10001)  return C_ADD;
    if (i[28:23] == 6'b100101) return (DATA_W == 32 && i[22]) ? C_ILL : C_MOVZ;
    if (i[30:26] == 5'b00101)  return C_B;
    if (i[30:25] == 6'b011010) return C_CB;
    if (i[31:24] == 8'h54)     return C_BC;
    // bit 22 selects load vs store, bit 23 is don't-care
    if (i[29:24] == 6'b111000 && !i[21] && i[11:10] == 2'b00) return C_LDST;
    return C_ILL;
  endfunction

  // Built at 64 bits then truncated, so sign extension holds for DATA_W=32 too.
  function automatic logic [DATA_W-1:0] gen(input logic [31:0] i);
    logic [63:0] v;
    v = '0;
    case (decode(i))
      C_ADD:       v = i[22] ? {40'd0, i[21:10], 12'd0} : {52'd0, i[21:10]};
      C_MOVZ:      v = {48'd0, i[20:5]} << {i[22:21], 4'd0};
      C_B:         v = {{36{i[25]}}, i[25:0], 2'b00};
      C_CB, C_BC:  v = {{43{i[23]}}, i[23:5], 2'b00};
      C_LDST:      v = {{55{i[20]}}, i[20:12]};
      default:     v = '0;
    endcase
    return v[DATA_W-1:0];
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v, r;
    {n, z, cf, v} = nzcv;
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cf;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cf & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return (c[0] && c != 4'hF) ? ~r : r;
  endfunction

  assign cls = decode(ir);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IF;
      ir       <= '0;
      constant <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF && instr_valid) begin
        ir       <= instruction;
        constant <= gen(instruction);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:    if (instr_valid) state_d = S_EX0;
      S_EX0:   state_d = (cls == C_LDST || (cls == C_B && ir[31])) ? S_EX1 : S_IF;
      S_EX1:   if (cls != C_LDST) state_d = S_IF;
               else if (mem_ready) state_d = ir[22] ? S_EX2 : S_IF;
      default: state_d = S_IF;
    endcase
  end

  // cw bits: [0]pc_inc [1]ir_load [2]reg_we [3]mem_we [4]mem_re [5]alu_b_const [6]pc_load [7]link_we
  always_comb begin
    cw        = 8'h00;
    instr_req = 1'b0;
    illegal   = 1'b0;
    if (reset) begin
      case (state_q)
        S_IF: begin
          instr_req = 1'b1;
          if (instr_valid) cw = 8'h03;
        end
        S_EX0: begin
          case (cls)
            C_ADD, C_MOVZ: cw = 8'h24;
            C_B:           cw = ir[31] ? 8'h80 : 8'h40;
            C_CB:          cw[6] = status[4] ^ ir[24];
            C_BC:          cw[6] = cond_ok(ir[3:0], status[3:0]);
            C_LDST:        cw = 8'h20;
            default:       illegal = 1'b1;
          endcase
        end
        S_EX1: begin
          if (cls == C_LDST) cw = ir[22] ? 8'h10 : 8'h08;
          else               cw = 8'h40;
        end
        default: cw = 8'h04;
      endcase
    end
  end

  always_comb begin
    control_word      = '0;
    control_word[7:0] = cw;
  end

  assign state = state_q;

`ifdef CTRL_SEQ_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) retired <= '0;
    else if (state_q != S_IF && state_d == S_IF && !(state_q == S_EX0 && cls == C_ILL))
      retired <= retired + 32'd1;
  end
`endif

endmodule
